misr_sig_check: RTL

MISR_SIG_CHECK -- requirements
Module: misr_sig_check

---
 rtl/misr_sig_check.sv | 82 ++++++++
 1 files changed

// File: rtl/misr_sig_check.sv
// 32-bit MISR signature compactor: compresses a run of data words and
// compares the final signature against a golden value.
module misr_sig_check (
  input  logic        CK,
  input  logic        RESET,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic [31:0] golden,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  // Feedback taps of x^32+x^16+x^11+x^4+1 (bits 16, 11, 4, 0)
  localparam logic [31:0] POLY_TAPS = 32'h0001_0811;

  state_t      state;
  state_t      state_next;
  logic [15:0] remaining;
  logic [31:0] golden_q;
  logic [31:0] sig_q;
  logic        pass_q;
  logic        accept_start;
  logic        transfer;
  logic [31:0] misr_next;

  assign accept_start = start && ((state == IDLE) || (state == DONE));
  assign transfer     = in_valid && (state == RUN);
  assign misr_next    = {sig_q[30:0], 1'b0} ^ in_data ^ ({32{sig_q[31]}} & POLY_TAPS);

  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_next = (word_count == 16'd0) ? CHECK : RUN;
      end
      RUN: begin
        if (in_valid && (remaining == 16'd1)) state_next = CHECK;
      end
      CHECK:   state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CK or posedge RESET) begin
    if (RESET) begin
      remaining <= 16'd0;
      golden_q  <= 32'd0;
      sig_q     <= 32'd0;
      pass_q    <= 1'b0;
    end else if (accept_start) begin
      remaining <= word_count;
      golden_q  <= golden;
      sig_q     <= 32'd0;
      pass_q    <= 1'b0;
    end else if (transfer) begin
      remaining <= remaining - 16'd1;
      sig_q     <= misr_next;
    end else if (state == CHECK) begin
      pass_q <= (sig_q == golden_q);
    end
  end

  // All outputs decode from registered state only
  assign in_ready  = (state == RUN);
  assign busy      = (state == RUN) || (state == CHECK);
  assign done      = (state == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule
